// File: rtl/reg_file_param_if.sv
// Bundles the two write ports and two read ports of reg_file_param.
// The master side is decode/writeback; the slave side is the register file.
interface reg_file_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              WRITEENABLE1;
    logic [ADDR_W-1:0] WRITEREG1;
    logic [DATA_W-1:0] WRITEDATA1;
    logic              WRITEENABLE2;
    logic [ADDR_W-1:0] WRITEREG2;
    logic [DATA_W-1:0] WRITEDATA2;
    logic [ADDR_W-1:0] READREG1;
    logic [ADDR_W-1:0] READREG2;
    logic [DATA_W-1:0] REGOUT1;
    logic [DATA_W-1:0] REGOUT2;
    logic              REGVALID1;
    logic              REGVALID2;

    modport master (
        output WRITEENABLE1, WRITEREG1, WRITEDATA1,
        output WRITEENABLE2, WRITEREG2, WRITEDATA2,
        output READREG1, READREG2,
        input  REGOUT1, REGOUT2, REGVALID1, REGVALID2
    );

    modport slave (
        input  WRITEENABLE1, WRITEREG1, WRITEDATA1,
        input  WRITEENABLE2, WRITEREG2, WRITEDATA2,
        input  READREG1, READREG2,
        output REGOUT1, REGOUT2, REGVALID1, REGVALID2
    );
endinterface

// File: rtl/reg_file_param.sv
// Two-write / two-read register file with sticky per-register valid bits.
// Optional macro BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input logic           CLK,
    input logic           RESET,
    reg_file_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] stored [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] rd_addr [2];

    assign rd_addr[0] = bus.READREG1;
    assign rd_addr[1] = bus.READREG2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(gi);
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign stored[gi] = '0;
                assign valid[gi]  = 1'b1;
            end else begin : g_store
                logic [DATA_W-1:0] data_reg;
                logic              valid_reg;
                logic              hit1;
                logic              hit2;

                assign hit1 = bus.WRITEENABLE1 && (bus.WRITEREG1 == ADDR);
                assign hit2 = bus.WRITEENABLE2 && (bus.WRITEREG2 == ADDR);

                // Port 2 is checked first so it wins an address collision.
                always_ff @(posedge CLK or posedge RESET) begin
                    if (RESET) begin
                        data_reg  <= '0;
                        valid_reg <= 1'b0;
                    end else if (hit2) begin
                        data_reg  <= bus.WRITEDATA2;
                        valid_reg <= 1'b1;
                    end else if (hit1) begin
                        data_reg  <= bus.WRITEDATA1;
                        valid_reg <= 1'b1;
                    end
                end

                assign stored[gi] = data_reg;
                assign valid[gi]  = valid_reg;
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            logic              vld;
`ifdef BYPASS_EN
            logic              fwd_ok;
            assign fwd_ok = !RESET && !(ZERO_REG != 0 && rd_addr[gi] == '0);
`endif
            always_comb begin
                data = stored[rd_addr[gi]];
                vld  = valid[rd_addr[gi]];
`ifdef BYPASS_EN
                if (fwd_ok && bus.WRITEENABLE2 && bus.WRITEREG2 == rd_addr[gi]) begin
                    data = bus.WRITEDATA2;
                    vld  = 1'b1;
                end else if (fwd_ok && bus.WRITEENABLE1 && bus.WRITEREG1 == rd_addr[gi]) begin
                    data = bus.WRITEDATA1;
                    vld  = 1'b1;
                end
`endif
            end
        end
    endgenerate

    assign bus.REGOUT1   = g_rd[0].data;
    assign bus.REGVALID1 = g_rd[0].vld;
    assign bus.REGOUT2   = g_rd[1].data;
    assign bus.REGVALID2 = g_rd[1].vld;
endmodule
